// File: rtl/mure_pkg.sv
// Shared trace-path types: widths and the micro-op entry handed to the trace FSM.
package mure_pkg;

  localparam int XLEN      = 64;
  localparam int ITYPE_LEN = 3;
  localparam int PRIV_LEN  = 2;
  localparam int CAUSE_LEN = 64;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic                 compressed;
    logic [ITYPE_LEN-1:0] itype;
    logic [PRIV_LEN-1:0]  priv;
  } uop_entry_s;

endpackage

// File: rtl/commit_serializer_if.sv
// Bundle between the CVA6 commit ports (master) and the commit serializer (slave).
interface commit_serializer_if #(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
);

  logic [NRET-1:0]                                valid_i;
  logic [NRET-1:0][mure_pkg::XLEN-1:0]            pc_i;
  logic [NRET-1:0]                                compressed_i;
  logic [NRET-1:0][mure_pkg::ITYPE_LEN-1:0]       itype_i;
  logic [mure_pkg::PRIV_LEN-1:0]                  priv_i;
  logic [mure_pkg::CAUSE_LEN-1:0]                 cause_i;
  logic [mure_pkg::XLEN-1:0]                      tval_i;
  logic                                           overflow_clr_i;

  mure_pkg::uop_entry_s                           uop_entry_o;
  logic [mure_pkg::CAUSE_LEN-1:0]                 cause_o;
  logic [mure_pkg::XLEN-1:0]                      tval_o;
  logic [$clog2(DEPTH+1)-1:0]                     count_o;
  logic                                           overflow_o;

  modport master (
    output valid_i, pc_i, compressed_i, itype_i, priv_i, cause_i, tval_i, overflow_clr_i,
    input  uop_entry_o, cause_o, tval_o, count_o, overflow_o
  );

  modport slave (
    input  valid_i, pc_i, compressed_i, itype_i, priv_i, cause_i, tval_i, overflow_clr_i,
    output uop_entry_o, cause_o, tval_o, count_o, overflow_o
  );

endinterface

// File: rtl/commit_serializer.sv
// Compacts up to NRET commits per cycle into a FIFO and replays them one per cycle in
// program order; groups that do not fit are dropped whole and flagged in a sticky bit.
module commit_serializer #(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  commit_serializer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef mure_pkg::uop_entry_s entry_t;

  entry_t                         mem_q   [DEPTH];
  entry_t                         mem_d   [DEPTH];
  logic [mure_pkg::CAUSE_LEN-1:0] cause_q [DEPTH];
  logic [mure_pkg::CAUSE_LEN-1:0] cause_d [DEPTH];
  logic [mure_pkg::XLEN-1:0]      tval_q  [DEPTH];
  logic [mure_pkg::XLEN-1:0]      tval_d  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [NRET-1:0] take;
  logic [CW-1:0]   slot [NRET];
  logic [CW-1:0]   grp_cnt;
  logic [CW-1:0]   free_slots;
  logic            stop;
  logic            pop;
  logic            push;

  // Each taken port gets its compacted slot; the first exception closes the group.
  always_comb begin : group_formation
    stop    = 1'b0;
    grp_cnt = '0;
    take    = '0;
    for (int i = 0; i < NRET; i++) begin
      slot[i] = '0;
    end
    for (int i = 0; i < NRET; i++) begin
      if (bus.valid_i[i] && !stop) begin
        take[i] = 1'b1;
        slot[i] = grp_cnt;
        grp_cnt = grp_cnt + CW'(1);
        if (bus.itype_i[i] == mure_pkg::ITYPE_LEN'(1)) begin
          stop = 1'b1;
        end
      end
    end
  end

  always_comb begin : fifo_next
    mem_d      = mem_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    pop        = (count_q != '0);
    free_slots = CW'(DEPTH) - count_q + CW'(pop);
    push       = (grp_cnt != '0) && (grp_cnt <= free_slots);

    for (int k = 0; k < NRET; k++) begin
      for (int i = 0; i < NRET; i++) begin
        if (push && take[i] && (slot[i] == CW'(k))) begin
          mem_d[wr_ptr_q + PW'(k)] = '{valid:      1'b1,
                                       pc:         bus.pc_i[i],
                                       compressed: bus.compressed_i[i],
                                       itype:      bus.itype_i[i],
                                       priv:       bus.priv_i};
          // Only the group-ending exception carries cause/tval.
          if (bus.itype_i[i] == mure_pkg::ITYPE_LEN'(1)) begin
            cause_d[wr_ptr_q + PW'(k)] = bus.cause_i;
            tval_d[wr_ptr_q + PW'(k)]  = bus.tval_i;
          end else begin
            cause_d[wr_ptr_q + PW'(k)] = '0;
            tval_d[wr_ptr_q + PW'(k)]  = '0;
          end
        end
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + grp_cnt[PW-1:0];
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (push ? grp_cnt : '0) - CW'(pop);

    if (bus.overflow_clr_i) begin
      overflow_d = 1'b0;
    end
    if ((grp_cnt != '0) && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin : head_output
    bus.uop_entry_o = '0;
    bus.cause_o     = '0;
    bus.tval_o      = '0;
    if (count_q != '0) begin
      bus.uop_entry_o = mem_q[rd_ptr_q];
      bus.cause_o     = cause_q[rd_ptr_q];
      bus.tval_o      = tval_q[rd_ptr_q];
    end
  end

  assign bus.count_o    = count_q;
  assign bus.overflow_o = overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin : ctrl_regs
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin : payload_regs
    mem_q   <= mem_d;
    cause_q <= cause_d;
    tval_q  <= tval_d;
  end

endmodule

// File: tb/tb_commit_serializer.sv
// Directed bench for commit_serializer: single/dual commits, exception truncation,
// overflow with whole-group drops, pointer wrap and mid-burst reset.
module tb_commit_serializer;

  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   total_checks = 0;
  int   bad_checks   = 0;

  always #5 clk_i = ~clk_i;

  commit_serializer_if #(.NRET(NRET), .DEPTH(DEPTH)) bus ();

  commit_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0]  valid,
                               input logic [63:0] pc0,
                               input logic [63:0] pc1,
                               input logic [1:0]  comp,
                               input logic [2:0]  it0,
                               input logic [2:0]  it1,
                               input logic [1:0]  priv,
                               input logic [63:0] cause,
                               input logic [63:0] tval);
    bus.valid_i      = valid;
    bus.pc_i[0]      = pc0;
    bus.pc_i[1]      = pc1;
    bus.compressed_i = comp;
    bus.itype_i[0]   = it0;
    bus.itype_i[1]   = it1;
    bus.priv_i       = priv;
    bus.cause_i      = cause;
    bus.tval_i       = tval;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 64'h0, 64'h0, 2'b00, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] exp_pc;

    rst_ni             = 1'b0;
    bus.overflow_clr_i = 1'b0;
    idle();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset.valid", 64'(bus.uop_entry_o.valid), 64'd0);
    checkOutput("reset.count", 64'(bus.count_o), 64'd0);
    checkOutput("reset.overflow", 64'(bus.overflow_o), 64'd0);
    checkOutput("reset.pc", bus.uop_entry_o.pc, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    $display("[TB] single commit");
    applyStimulus(2'b01, 64'h8000_0000, 64'h0, 2'b01, 3'd0, 3'd0, 2'd3, 64'h0, 64'h0);
    tick();
    idle();
    checkOutput("single.valid", 64'(bus.uop_entry_o.valid), 64'd1);
    checkOutput("single.pc", bus.uop_entry_o.pc, 64'h8000_0000);
    checkOutput("single.compressed", 64'(bus.uop_entry_o.compressed), 64'd1);
    checkOutput("single.priv", 64'(bus.uop_entry_o.priv), 64'd3);
    checkOutput("single.count", 64'(bus.count_o), 64'd1);
    tick();
    checkOutput("single.valid_after", 64'(bus.uop_entry_o.valid), 64'd0);
    checkOutput("single.count_after", 64'(bus.count_o), 64'd0);

    $display("[TB] dual commit");
    applyStimulus(2'b11, 64'h100, 64'h104, 2'b00, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0);
    tick();
    idle();
    checkOutput("dual.pc0", bus.uop_entry_o.pc, 64'h100);
    checkOutput("dual.count0", 64'(bus.count_o), 64'd2);
    tick();
    checkOutput("dual.valid1", 64'(bus.uop_entry_o.valid), 64'd1);
    checkOutput("dual.pc1", bus.uop_entry_o.pc, 64'h104);
    tick();
    checkOutput("dual.valid_after", 64'(bus.uop_entry_o.valid), 64'd0);
    checkOutput("dual.overflow", 64'(bus.overflow_o), 64'd0);

    $display("[TB] exception truncation");
    applyStimulus(2'b11, 64'h1FC, 64'h200, 2'b00, 3'd1, 3'd0, 2'd1, 64'd2, 64'hDEAD);
    tick();
    idle();
    checkOutput("exc.pc", bus.uop_entry_o.pc, 64'h1FC);
    checkOutput("exc.itype", 64'(bus.uop_entry_o.itype), 64'd1);
    checkOutput("exc.cause", bus.cause_o, 64'd2);
    checkOutput("exc.tval", bus.tval_o, 64'hDEAD);
    checkOutput("exc.count", 64'(bus.count_o), 64'd1);
    tick();
    checkOutput("exc.valid_after", 64'(bus.uop_entry_o.valid), 64'd0);
    checkOutput("exc.overflow", 64'(bus.overflow_o), 64'd0);

    $display("[TB] compaction of port 1 alone");
    applyStimulus(2'b10, 64'h0, 64'h300, 2'b10, 3'd0, 3'd2, 2'd0, 64'd7, 64'h55);
    tick();
    idle();
    checkOutput("compact.pc", bus.uop_entry_o.pc, 64'h300);
    checkOutput("compact.itype", 64'(bus.uop_entry_o.itype), 64'd2);
    checkOutput("compact.compressed", 64'(bus.uop_entry_o.compressed), 64'd1);
    checkOutput("compact.cause", bus.cause_o, 64'd0);
    checkOutput("compact.tval", bus.tval_o, 64'd0);
    checkOutput("compact.count", 64'(bus.count_o), 64'd1);
    tick();
    checkOutput("compact.valid_after", 64'(bus.uop_entry_o.valid), 64'd0);

    // Dual groups for 10 cycles: groups 7 and 9 find only one free slot and are dropped.
    $display("[TB] fill and overflow");
    for (int t = 0; t < 16; t++) begin
      if (t < 10) begin
        applyStimulus(2'b11, 64'h1000 + 64'(8 * t), 64'h1004 + 64'(8 * t),
                      2'b00, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0);
      end else begin
        idle();
      end
      tick();
      idle();
      exp_pc = (t < 14) ? 64'h1000 + 64'(4 * t) : 64'h1040 + 64'(4 * (t - 14));
      checkOutput("fill.valid", 64'(bus.uop_entry_o.valid), 64'd1);
      checkOutput("fill.pc", bus.uop_entry_o.pc, exp_pc);
      if (t == 6) begin
        checkOutput("fill.count_full", 64'(bus.count_o), 64'd8);
        checkOutput("fill.overflow_clear", 64'(bus.overflow_o), 64'd0);
      end
      if (t == 7) begin
        checkOutput("fill.overflow_set", 64'(bus.overflow_o), 64'd1);
        checkOutput("fill.count_after_drop", 64'(bus.count_o), 64'd7);
      end
      if (t == 8) begin
        checkOutput("fill.count_refill", 64'(bus.count_o), 64'd8);
      end
    end
    tick();
    checkOutput("fill.drained_valid", 64'(bus.uop_entry_o.valid), 64'd0);
    checkOutput("fill.drained_count", 64'(bus.count_o), 64'd0);
    checkOutput("fill.overflow_sticky", 64'(bus.overflow_o), 64'd1);
    bus.overflow_clr_i = 1'b1;
    tick();
    bus.overflow_clr_i = 1'b0;
    checkOutput("fill.overflow_cleared", 64'(bus.overflow_o), 64'd0);

    $display("[TB] pointer wrap");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2'b01, 64'h4000 + 64'(4 * i), 64'h0, 2'b00, 3'd0, 3'd0,
                    2'(i % 4), 64'h0, 64'h0);
      tick();
      idle();
      checkOutput("wrap.pc", bus.uop_entry_o.pc, 64'h4000 + 64'(4 * i));
      checkOutput("wrap.priv", 64'(bus.uop_entry_o.priv), 64'(i % 4));
      checkOutput("wrap.count", 64'(bus.count_o), 64'd1);
      if (i % 3 == 2) begin
        tick();
        checkOutput("wrap.gap_valid", 64'(bus.uop_entry_o.valid), 64'd0);
      end
    end
    tick();
    checkOutput("wrap.count_end", 64'(bus.count_o), 64'd0);

    $display("[TB] reset mid-burst");
    for (int g = 0; g < 4; g++) begin
      applyStimulus(2'b11, 64'h6000 + 64'(8 * g), 64'h6004 + 64'(8 * g),
                    2'b00, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0);
      tick();
    end
    idle();
    checkOutput("rst.count_before", 64'(bus.count_o), 64'd5);
    rst_ni = 1'b0;
    #1;
    checkOutput("rst.valid_low", 64'(bus.uop_entry_o.valid), 64'd0);
    checkOutput("rst.count_low", 64'(bus.count_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    applyStimulus(2'b01, 64'h7000, 64'h0, 2'b00, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0);
    tick();
    idle();
    checkOutput("rst.new_valid", 64'(bus.uop_entry_o.valid), 64'd1);
    checkOutput("rst.new_pc", bus.uop_entry_o.pc, 64'h7000);
    checkOutput("rst.new_count", 64'(bus.count_o), 64'd1);
    tick();
    checkOutput("rst.new_drained", 64'(bus.uop_entry_o.valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/commit_serializer.md
Name: commit_serializer

Overview:
- Sits directly upstream of the instruction-trace FSM.
- Takes up to NRET retired instructions per cycle from the CVA6 commit ports and buffers them in a FIFO.
- Presents them one per cycle as a mure_pkg::uop_entry_s, with the matching cause/tval, in program order.
- Absorbs dual-commit bursts; the core is never stalled, so overflow drops data and is flagged.

Parameters:
NRET, 2, number of commit ports sampled per cycle (1..4)
DEPTH, 8, FIFO entries; power of two, >= 2*NRET

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
valid_i  input  NRET  per-port commit valid
pc_i  input  NRET x XLEN  per-port retired PC
compressed_i  input  NRET  per-port 16-bit instruction flag
itype_i  input  NRET x ITYPE_LEN  per-port itype (0 standard, 1 exception, >1 other special)
priv_i  input  PRIV_LEN  current privilege, shared by all ports in the cycle
cause_i  input  CAUSE_LEN  exception cause, valid when some valid port has itype 1
tval_i  input  XLEN  exception tval, same qualification as cause_i
overflow_clr_i  input  1  clears overflow_o
uop_entry_o  output  mure_pkg::uop_entry_s  head entry (valid, pc, compressed, itype, priv)
cause_o  output  CAUSE_LEN  cause stored with head entry
tval_o  output  XLEN  tval stored with head entry
count_o  output  $clog2(DEPTH+1)  current occupancy
overflow_o  output  1  sticky: a commit group was dropped

Behaviour:
- Reset (async assert, sync release): pointers and count 0; overflow_o 0; uop_entry_o.valid 0; all other outputs 0.
- Group formation, each cycle:
  - Valid ports are taken in ascending index and compacted (port 1 valid with port 0 invalid is written as a single entry).
  - The first valid port with itype==1 ends the group; valid ports at higher index are discarded, with no overflow.
  - Only that exception entry stores cause_i/tval_i; every other entry stores 0 for both.
- Pop:
  - uop_entry_o.valid = (count != 0).
  - The FSM consumes every cycle with no ready signal, so a pop occurs every cycle the FIFO is non-empty.
  - Head fields are driven from storage; outputs are all-zero when empty.
- Latency: a group written in cycle N appears at the output from cycle N+1. A 2-entry group on an empty FIFO occupies cycles N+1 and N+2.
- Push and pop in the same cycle:
  - Capacity check uses free = DEPTH - count + pop.
  - count_next = count + pushed - pop.
- Overflow:
  - If group size > free, the whole group is dropped (all-or-nothing) and overflow_o sets the next cycle.
  - The pop still occurs normally.
- overflow_o clearing:
  - Cleared by overflow_clr_i.
  - Set has priority over a clear in the same cycle.
- Pointers: write/read pointers are log2(DEPTH) bits and wrap modulo DEPTH. count_o distinguishes full from empty.
- Ordering: output order equals commit order. Within a cycle, the lower port index comes first.
- priv_i is latched per entry.
- An asynchronous reset mid-burst discards all contents immediately; the output is invalid while rst_ni is low.

Test Plan:
- Single commit: port0 valid, pc=0x8000_0000, compressed=1, itype=0, cycle 0 → cycle 1: uop_entry_o.valid=1, pc=0x8000_0000, compressed=1; cycle 2: valid=0; count_o 1 then 0.
- Dual commit: ports 0/1 with pc 0x100/0x104, itype 0 → cycle 1 pc=0x100, cycle 2 pc=0x104, no gap, no overflow.
- Exception truncation: port0 itype=1, cause=2, tval=0xDEAD; port1 valid pc=0x200 → single entry itype=1, cause_o=2, tval_o=0xDEAD; 0x200 never emitted; overflow_o stays 0.
- Fill/overflow: dual commits every cycle for 10 cycles, DEPTH=8 → count_o saturates at 8. The first dropped group sets overflow_o. Output PCs are contiguous program order with whole groups missing, never half groups. overflow_clr_i pulse → 0.
- Wrap-around: 20 single commits with gaps → pointers wrap ≥2 times, all 20 PCs emitted in order, count_o returns to 0.
- Reset mid-operation: 5 entries queued, drop rst_ni for one cycle → uop_entry_o.valid=0 immediately, count_o=0. A new commit afterwards emits after one cycle with the correct pc.
